// File: rtl/sata_irq_coalesce_pkg.sv
// Shared definitions for the SATA interrupt status/coalescing block.
// - ccc_state_e : coalescing FSM state encoding
// - popcount()  : number of set bits in a (zero-extended) event vector
package sata_irq_coalesce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } ccc_state_e;

  // popcount operates on a fixed-width vector; callers zero-extend into it.
  localparam int unsigned POP_MAX = 64;
  localparam int unsigned POP_W   = 7;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sata_irq_coalesce_tick_div.sv
// Timeout prescaler: counts 0..C_TICK_DIV-1 while enabled and emits a
// one-cycle tick on each wrap.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : count enable
//   clr_i     : synchronous clear (dominates en_i)
//   tick_o    : high in the cycle the counter wraps
module sata_tick_div #(
  parameter int unsigned C_TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = (C_TICK_DIV > 2) ? $clog2(C_TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(C_TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/sata_irq_coalesce.sv
// Sticky W1C event status plus level interrupt with optional
// count/timeout interrupt coalescing.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   evt         : single-cycle event pulses from the synchronizers
//   ie          : per-event interrupt enable
//   stat_wr     : status write strobe; stat_wdata is the write-1-to-clear mask
//   stat        : sticky event status
//   ccc_en      : coalescing enable
//   ccc_cc      : completion count threshold (0 = count criterion off)
//   ccc_tv      : timeout in ticks (0 = timeout criterion off)
//   ccc_clr     : clears ccc_sts
//   ccc_sts     : sticky coalescing-fired status
//   ccc_cnt     : current batch event count
//   irq         : level interrupt (ccc_sts when coalescing, else stat & ie)
module sata_irq_coalesce
  import sata_irq_coalesce_pkg::*;
#(
  parameter int unsigned C_NUM_EVT  = 8,
  parameter int unsigned C_CNT_W    = 8,
  parameter int unsigned C_TMO_W    = 16,
  parameter int unsigned C_TICK_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [C_NUM_EVT-1:0] evt,
  input  logic [C_NUM_EVT-1:0] ie,
  input  logic                 stat_wr,
  input  logic [C_NUM_EVT-1:0] stat_wdata,
  output logic [C_NUM_EVT-1:0] stat,
  input  logic                 ccc_en,
  input  logic [C_CNT_W-1:0]   ccc_cc,
  input  logic [C_TMO_W-1:0]   ccc_tv,
  input  logic                 ccc_clr,
  output logic                 ccc_sts,
  output logic [C_CNT_W-1:0]   ccc_cnt,
  output logic                 irq
);

  localparam int unsigned SUM_W = C_CNT_W + POP_W;
  localparam logic [C_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [C_TMO_W-1:0] TMO_MAX = '1;

  ccc_state_e          state_q, state_d;
  logic [C_NUM_EVT-1:0] stat_q, stat_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [C_TMO_W-1:0]   timer_q, timer_d, timer_inc;
  logic                 sts_q, sts_d;
  logic                 irq_q, irq_d;
  logic [POP_MAX-1:0]   pop_in;
  logic [POP_W-1:0]     inc;
  logic [SUM_W-1:0]     sum;
  logic                 run, tick, fire, fire_cnt, fire_tmo;

  // Status: set has priority over W1C clear.
  always_comb begin
    stat_d = (stat_q & ~({C_NUM_EVT{stat_wr}} & stat_wdata)) | evt;
  end

  always_comb begin
    pop_in = '0;
    pop_in[C_NUM_EVT-1:0] = evt & ie;
    inc = popcount(pop_in);
  end

  // Prescaler only runs while a batch is accumulating; any other cycle
  // clears it so a new batch always starts from a fresh tick period.
  assign run = ccc_en && (state_q == ACCUM);

  sata_tick_div #(
    .C_TICK_DIV (C_TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (run),
    .clr_i  (~run),
    .tick_o (tick)
  );

  always_comb begin
    // In IDLE the held count is zero, so the batch starts from inc alone.
    sum       = SUM_W'((state_q == ACCUM) ? cnt_q : '0) + SUM_W'(inc);
    cnt_nxt   = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[C_CNT_W-1:0];
    timer_inc = (timer_q == TMO_MAX) ? timer_q : timer_q + 1'b1;
    fire_cnt  = (ccc_cc != '0) && (cnt_nxt >= ccc_cc);
    fire_tmo  = (ccc_tv != '0) && tick && (timer_inc == ccc_tv);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    sts_d   = sts_q;
    fire    = 1'b0;

    if (!ccc_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inc != '0) begin
            if (fire_cnt) begin
              fire = 1'b1;
            end else begin
              state_d = ACCUM;
              cnt_d   = cnt_nxt;
              timer_d = '0;
            end
          end
        end
        ACCUM: begin
          if (fire_cnt || fire_tmo) begin
            fire = 1'b1;
          end else begin
            cnt_d = cnt_nxt;
            if (tick) begin
              timer_d = timer_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Fire absorbs the current cycle's events and beats a coincident clear.
    if (fire) begin
      sts_d   = 1'b1;
      cnt_d   = '0;
      timer_d = '0;
      state_d = IDLE;
    end else if (ccc_clr) begin
      sts_d = 1'b0;
    end
  end

  always_comb begin
    irq_d = ccc_en ? sts_d : |(stat_d & ie);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stat_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      sts_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sts_q   <= sts_d;
      irq_q   <= irq_d;
    end
  end

  assign stat    = stat_q;
  assign ccc_sts = sts_q;
  assign ccc_cnt = cnt_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_sata_irq_coalesce.sv
module tb_sata_irq_coalesce;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  evt, ie, stat_wdata, stat, ccc_cc, ccc_cnt;
  logic        stat_wr, ccc_en, ccc_clr, ccc_sts, irq;
  logic [15:0] ccc_tv;

  int unsigned nchk  = 0;
  int unsigned npass = 0;

  always #5 clk = ~clk;

  sata_irq_coalesce #(
    .C_NUM_EVT  (8),
    .C_CNT_W    (8),
    .C_TMO_W    (16),
    .C_TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evt        (evt),
    .ie         (ie),
    .stat_wr    (stat_wr),
    .stat_wdata (stat_wdata),
    .stat       (stat),
    .ccc_en     (ccc_en),
    .ccc_cc     (ccc_cc),
    .ccc_tv     (ccc_tv),
    .ccc_clr    (ccc_clr),
    .ccc_sts    (ccc_sts),
    .ccc_cnt    (ccc_cnt),
    .irq        (irq)
  );

  typedef struct {
    logic [7:0]  evt;
    logic [7:0]  ie;
    logic        wr;
    logic [7:0]  wd;
    logic        en;
    logic [7:0]  cc;
    logic [15:0] tv;
    logic        clr;
    logic [7:0]  e_stat;
    logic        e_irq;
    logic        e_sts;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] v_evt, input logic [7:0] v_ie,
                     input logic v_wr, input logic [7:0] v_wd,
                     input logic v_en, input logic [7:0] v_cc,
                     input logic [15:0] v_tv, input logic v_clr,
                     input logic [7:0] x_stat, input logic x_irq,
                     input logic x_sts, input logic [7:0] x_cnt);
    vec_t v;
    v.evt = v_evt; v.ie = v_ie; v.wr = v_wr; v.wd = v_wd;
    v.en = v_en; v.cc = v_cc; v.tv = v_tv; v.clr = v_clr;
    v.e_stat = x_stat; v.e_irq = x_irq; v.e_sts = x_sts; v.e_cnt = x_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] x_stat, input logic x_irq,
                           input logic x_sts, input logic [7:0] x_cnt);
    check({tag, ".stat"}, 32'(stat), 32'(x_stat));
    check({tag, ".irq"}, 32'(irq), 32'(x_irq));
    check({tag, ".sts"}, 32'(ccc_sts), 32'(x_sts));
    check({tag, ".cnt"}, 32'(ccc_cnt), 32'(x_cnt));
  endtask

  initial begin
    int unsigned n;
    bit          seen;

    rst = 1'b1; evt = '0; ie = '0; stat_wr = 1'b0; stat_wdata = '0;
    ccc_en = 1'b0; ccc_cc = '0; ccc_tv = '0; ccc_clr = 1'b0;

    //      evt    ie     wr  wd     en  cc  tv  clr  stat   irq sts cnt
    add(8'h00, 8'h00, 0, 8'h00, 0, 3, 0, 0, 8'h00, 0, 0, 0);   // idle after reset
    add(8'h04, 8'h05, 0, 8'h00, 0, 3, 0, 0, 8'h04, 1, 0, 0);   // enabled event
    add(8'h00, 8'h05, 0, 8'h00, 0, 3, 0, 0, 8'h04, 1, 0, 0);   // sticky
    add(8'h02, 8'h05, 0, 8'h00, 0, 3, 0, 0, 8'h06, 1, 0, 0);
    add(8'h00, 8'h05, 1, 8'h04, 0, 3, 0, 0, 8'h02, 0, 0, 0);   // clear last enabled
    add(8'h04, 8'h05, 1, 8'h04, 0, 3, 0, 0, 8'h06, 1, 0, 0);   // set beats clear
    add(8'h00, 8'h00, 0, 8'h00, 0, 3, 0, 0, 8'h06, 0, 0, 0);   // ie change
    add(8'h00, 8'h02, 0, 8'h00, 0, 3, 0, 0, 8'h06, 1, 0, 0);
    add(8'h00, 8'h05, 1, 8'hFF, 0, 3, 0, 0, 8'h00, 0, 0, 0);
    add(8'h01, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h01, 0, 0, 1);   // batch start
    add(8'h00, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h01, 0, 0, 1);
    add(8'h10, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h11, 0, 0, 2);
    add(8'h00, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h11, 0, 0, 2);
    add(8'h80, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h91, 1, 1, 0);   // count fire
    add(8'h00, 8'hFF, 0, 8'h00, 1, 3, 0, 1, 8'h91, 0, 0, 0);   // ccc_clr
    add(8'h07, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h97, 1, 1, 0);   // fire from IDLE
    add(8'h00, 8'hFF, 0, 8'h00, 1, 3, 0, 1, 8'h97, 0, 0, 0);
    add(8'h08, 8'h01, 0, 8'h00, 1, 3, 0, 0, 8'h9F, 0, 0, 0);   // masked: no count
    add(8'h03, 8'hFF, 0, 8'h00, 1, 3, 0, 0, 8'h9F, 0, 0, 2);
    add(8'h00, 8'hFF, 0, 8'h00, 1, 2, 0, 0, 8'h9F, 1, 1, 0);   // threshold lowered
    add(8'h00, 8'hFF, 0, 8'h00, 1, 2, 0, 1, 8'h9F, 0, 0, 0);
    add(8'h01, 8'hFF, 0, 8'h00, 1, 5, 0, 0, 8'h9F, 0, 0, 1);
    add(8'h00, 8'hFF, 0, 8'h00, 0, 5, 0, 0, 8'h9F, 1, 0, 0);   // en drop
    add(8'h00, 8'hFF, 1, 8'hFF, 0, 5, 0, 0, 8'h00, 0, 0, 0);

    #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 8'h00);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    foreach (vecs[i]) begin
      evt = vecs[i].evt; ie = vecs[i].ie; stat_wr = vecs[i].wr; stat_wdata = vecs[i].wd;
      ccc_en = vecs[i].en; ccc_cc = vecs[i].cc; ccc_tv = vecs[i].tv; ccc_clr = vecs[i].clr;
      cyc();
      check_all($sformatf("vec%0d", i), vecs[i].e_stat, vecs[i].e_irq, vecs[i].e_sts, vecs[i].e_cnt);
    end
    evt = '0; stat_wr = 1'b0; ccc_clr = 1'b0;

    // Count threshold with spaced single events.
    ccc_en = 1'b1; ccc_cc = 8'd3; ccc_tv = '0; ie = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      repeat (9) cyc();
      evt = 8'(1 << k);
      cyc();
      evt = '0;
      if (k < 2) begin
        check($sformatf("spaced.cnt%0d", k), 32'(ccc_cnt), 32'(k + 1));
        check($sformatf("spaced.sts%0d", k), 32'(ccc_sts), 32'd0);
      end else begin
        check("spaced.fire_sts", 32'(ccc_sts), 32'd1);
        check("spaced.fire_irq", 32'(irq), 32'd1);
        check("spaced.fire_cnt", 32'(ccc_cnt), 32'd0);
      end
    end
    cyc();
    check("spaced.sticky", 32'(ccc_sts), 32'd1);
    ccc_clr = 1'b1; cyc(); ccc_clr = 1'b0;
    check("spaced.clr", 32'(ccc_sts), 32'd0);

    // Timeout: 2 ticks of 4 cycles.
    ccc_cc = 8'd10; ccc_tv = 16'd2;
    evt = 8'h01; cyc(); evt = '0;
    check("tmo.cnt_start", 32'(ccc_cnt), 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      cyc();
      n++;
      seen = ccc_sts;
    end
    check("tmo.cycles", n, 32'd8);
    check("tmo.cnt_zero", 32'(ccc_cnt), 32'd0);
    ccc_clr = 1'b1; cyc(); ccc_clr = 1'b0;

    // Clear coincident with fire: fire wins.
    ccc_cc = 8'd1; ccc_tv = '0;
    evt = 8'h01; ccc_clr = 1'b1; cyc(); evt = '0; ccc_clr = 1'b0;
    check("coll.sts", 32'(ccc_sts), 32'd1);
    cyc();
    ccc_clr = 1'b1; cyc(); ccc_clr = 1'b0;
    check("coll.clr_sts", 32'(ccc_sts), 32'd0);
    check("coll.clr_irq", 32'(irq), 32'd0);

    // Saturation with both criteria disabled; ccc_sts retained across en drop.
    evt = 8'h01; cyc();
    check("sat.pre_sts", 32'(ccc_sts), 32'd1);
    ccc_cc = '0; ccc_tv = '0; evt = 8'hFF;
    repeat (31) cyc();
    check("sat.cnt248", 32'(ccc_cnt), 32'd248);
    cyc();
    check("sat.cnt255", 32'(ccc_cnt), 32'd255);
    repeat (5) cyc();
    check("sat.hold", 32'(ccc_cnt), 32'd255);
    evt = '0; ccc_en = 1'b0; cyc();
    check("sat.en_drop_cnt", 32'(ccc_cnt), 32'd0);
    check("sat.en_drop_sts", 32'(ccc_sts), 32'd1);

    // Asynchronous reset mid-batch.
    ccc_en = 1'b1; ccc_cc = 8'd5; evt = 8'h01; cyc(); evt = '0;
    check("rst.pre_cnt", 32'(ccc_cnt), 32'd1);
    #2 rst = 1'b1;
    #1 check_all("rst.async", 8'h00, 1'b0, 1'b0, 8'h00);
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    check_all("rst.after", 8'h00, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
